// File: rtl/cond_unit.sv
// Condition-evaluation stage: stores the NZCV flags, qualifies write/branch
// requests against the instruction condition code and counts skipped instructions.
module cond_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             flush,
  input  logic [3:0]       cond,
  input  logic             flag_we,
  input  logic             Neg,
  input  logic             Z,
  input  logic             C,
  input  logic             V,
  input  logic             reg_write_req,
  input  logic             mem_write_req,
  input  logic             branch_req,
  output logic             reg_write_en,
  output logic             mem_write_en,
  output logic             pc_src,
  output logic             exec_valid,
  output logic [3:0]       nzcv,
  output logic [CNT_W-1:0] skipped_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic n_f, z_f, c_f, v_f;
  logic pass;
  logic issued;
  logic executed;
  logic skipped;

  assign n_f = nzcv[3];
  assign z_f = nzcv[2];
  assign c_f = nzcv[1];
  assign v_f = nzcv[0];

  // Conditions look only at the stored flags, never at this cycle's ALU flags.
  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    pass = 1'b0;
    case (cond)
      4'b0000: pass = z_f;
      4'b0001: pass = !z_f;
      4'b0010: pass = c_f;
      4'b0011: pass = !c_f;
      4'b0100: pass = n_f;
      4'b0101: pass = !n_f;
      4'b0110: pass = v_f;
      4'b0111: pass = !v_f;
      4'b1000: pass = c_f && !z_f;
      4'b1001: pass = !c_f || z_f;
      4'b1010: pass = (n_f == v_f);
      4'b1011: pass = (n_f != v_f);
      4'b1100: pass = !z_f && (n_f == v_f);
      4'b1101: pass = z_f || (n_f != v_f);
      default: pass = 1'b1;
    endcase
  end

  assign issued   = valid && !flush;
  assign executed = issued && pass;
  assign skipped  = issued && !pass;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: all state updates use non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      nzcv          <= 4'b0000;
      skipped_count <= '0;
      reg_write_en  <= 1'b0;
      mem_write_en  <= 1'b0;
      pc_src        <= 1'b0;
      exec_valid    <= 1'b0;
    end else begin
      reg_write_en <= executed && reg_write_req;
      mem_write_en <= executed && mem_write_req;
      pc_src       <= executed && branch_req;
      exec_valid   <= executed;

      if (executed && flag_we) begin
        nzcv <= {Neg, Z, C, V};
      end

      // Counter saturates rather than wrapping.
      if (skipped && (skipped_count != CNT_MAX)) begin
        skipped_count <= skipped_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios then randomized traffic,
// compared against a behavioural model; a CNT_W=2 instance exercises saturation.
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic       valid;
  logic       flush;
  logic [3:0] cond;
  logic       flag_we;
  logic       Neg, Z, C, V;
  logic       reg_write_req, mem_write_req, branch_req;

  logic       reg_write_en, mem_write_en, pc_src, exec_valid;
  logic [3:0] nzcv;
  logic [7:0] skipped_count;

  logic       s_reg_write_en, s_mem_write_en, s_pc_src, s_exec_valid;
  logic [3:0] s_nzcv;
  logic [1:0] s_skipped_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m_nzcv;
  int         m_cnt8;
  int         m_cnt2;
  logic       m_rwe, m_mwe, m_pcs, m_ev;

  cond_unit #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .valid(valid), .flush(flush), .cond(cond),
    .flag_we(flag_we), .Neg(Neg), .Z(Z), .C(C), .V(V),
    .reg_write_req(reg_write_req), .mem_write_req(mem_write_req),
    .branch_req(branch_req), .reg_write_en(reg_write_en),
    .mem_write_en(mem_write_en), .pc_src(pc_src), .exec_valid(exec_valid),
    .nzcv(nzcv), .skipped_count(skipped_count)
  );

  cond_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .valid(valid), .flush(flush), .cond(cond),
    .flag_we(flag_we), .Neg(Neg), .Z(Z), .C(C), .V(V),
    .reg_write_req(reg_write_req), .mem_write_req(mem_write_req),
    .branch_req(branch_req), .reg_write_en(s_reg_write_en),
    .mem_write_en(s_mem_write_en), .pc_src(s_pc_src), .exec_valid(s_exec_valid),
    .nzcv(s_nzcv), .skipped_count(s_skipped_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Condition codes come in complementary pairs; odd codes invert the even one,
  // except 111x which is always true.
  function automatic bit model_pass(input logic [3:0] cd, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cd >> 1)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;          // unsigned higher
      5: base = (n == v);         // signed >=
      6: base = !z && (n == v);   // signed >
      default: return 1'b1;
    endcase
    return cd[0] ? !base : base;
  endfunction

  task automatic step(input logic rst, input logic vl, input logic fl,
                      input logic [3:0] cd, input logic fwe, input logic [3:0] flags,
                      input logic rw, input logic mw, input logic br);
    bit is_issued, ok;
    reset = rst; valid = vl; flush = fl; cond = cd; flag_we = fwe;
    {Neg, Z, C, V} = flags;
    reg_write_req = rw; mem_write_req = mw; branch_req = br;

    if (rst) begin
      m_nzcv = 4'b0000; m_cnt8 = 0; m_cnt2 = 0;
      m_rwe = 0; m_mwe = 0; m_pcs = 0; m_ev = 0;
    end else begin
      is_issued = vl && !fl;
      ok = is_issued && model_pass(cd, m_nzcv);
      m_rwe = ok && rw;
      m_mwe = ok && mw;
      m_pcs = ok && br;
      m_ev  = ok;
      if (ok && fwe) m_nzcv = flags;
      if (is_issued && !ok) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
    end

    @(posedge clk);
    #1;
    check("reg_write_en", reg_write_en, m_rwe);
    check("mem_write_en", mem_write_en, m_mwe);
    check("pc_src",       pc_src,       m_pcs);
    check("exec_valid",   exec_valid,   m_ev);
    check("nzcv",         nzcv,         m_nzcv);
    check("skipped_count", skipped_count, m_cnt8);
    check("sat_nzcv",     s_nzcv,       m_nzcv);
    check("sat_exec_valid", s_exec_valid, m_ev);
    check("sat_skipped_count", s_skipped_count, m_cnt2);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; flush = 1'b0; cond = 4'h0; flag_we = 1'b0;
    {Neg, Z, C, V} = 4'h0;
    reg_write_req = 1'b0; mem_write_req = 1'b0; branch_req = 1'b0;
    m_nzcv = 4'h0; m_cnt8 = 0; m_cnt2 = 0;
    m_rwe = 0; m_mwe = 0; m_pcs = 0; m_ev = 0;

    // Reset wins over a fully-armed instruction
    step(1, 1, 0, 4'hE, 1, 4'hF, 1, 1, 1);
    check("reset_nzcv", nzcv, 4'h0);
    check("reset_exec_valid", exec_valid, 1'b0);
    check("reset_count", skipped_count, 8'd0);

    // After reset EQ fails; its flag write is suppressed and it counts as skipped
    step(0, 1, 0, 4'h0, 1, 4'hF, 1, 0, 0);
    check("skip_fw_nzcv", nzcv, 4'h0);
    check("skip_fw_rwe", reg_write_en, 1'b0);
    check("skip_fw_count", skipped_count, 8'd1);
    // NE passes
    step(0, 1, 0, 4'h1, 0, 4'h0, 1, 0, 0);
    check("ne_pass_ev", exec_valid, 1'b1);

    // Flag write under AL
    step(0, 1, 0, 4'hE, 1, 4'b0100, 1, 0, 0);
    check("fw_nzcv", nzcv, 4'b0100);
    check("fw_rwe", reg_write_en, 1'b1);
    check("fw_ev", exec_valid, 1'b1);

    // Dependent condition uses the just-written flags
    step(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 1);
    check("eq_branch", pc_src, 1'b1);
    step(0, 1, 0, 4'h1, 0, 4'h0, 0, 0, 1);
    check("ne_branch", pc_src, 1'b0);
    check("ne_count", skipped_count, 8'd2);

    // Signed compares: N=V
    step(0, 1, 0, 4'hE, 1, 4'b1001, 0, 0, 0);
    step(0, 1, 0, 4'hA, 0, 4'h0, 0, 0, 0);
    check("ge_pass", exec_valid, 1'b1);
    step(0, 1, 0, 4'hB, 0, 4'h0, 0, 0, 0);
    check("lt_skip", exec_valid, 1'b0);
    // N!=V
    step(0, 1, 0, 4'hE, 1, 4'b1000, 0, 0, 0);
    step(0, 1, 0, 4'hC, 0, 4'h0, 0, 0, 0);
    check("gt_skip", exec_valid, 1'b0);
    step(0, 1, 0, 4'hD, 0, 4'h0, 0, 0, 0);
    check("le_pass", exec_valid, 1'b1);
    check("count_after_cmp", skipped_count, 8'd4);

    // Flush squashes everything
    step(0, 1, 1, 4'hE, 1, 4'b0110, 0, 1, 0);
    check("flush_nzcv", nzcv, 4'b1000);
    check("flush_mwe", mem_write_en, 1'b0);
    check("flush_count", skipped_count, 8'd4);

    // Saturation of the 2-bit counter
    step(0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    check("sat_hold", s_skipped_count, 2'd3);
    check("wide_count", skipped_count, 8'd5);

    // Mid-stream reset discards the instruction in the reset cycle
    step(1, 1, 0, 4'hE, 1, 4'b1111, 1, 1, 1);
    check("midrst_nzcv", nzcv, 4'h0);
    check("midrst_pc_src", pc_src, 1'b0);
    check("midrst_sat_count", s_skipped_count, 2'd0);
    step(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    check("post_rst_nzcv", nzcv, 4'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic rr, vv, ff;
      rr = ($urandom_range(31) == 0);
      vv = ($urandom_range(3) != 0);
      ff = ($urandom_range(3) == 0);
      step(rr, vv, ff, 4'($urandom_range(15)), 1'($urandom_range(1)),
           4'($urandom_range(15)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
